// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: the pipeline writeback (port A) and a long-latency
// unit (port B, through a one-entry buffer with age-based priority) share one write port.
// A scoreboard of registers still awaiting a port-B result drives the decode stall.
module rf_wb_sched #(
  parameter int unsigned AGE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_we_i,
  input  logic [4:0]  a_rd_i,
  input  logic [31:0] a_wd_i,
  input  logic        b_valid_i,
  input  logic [4:0]  b_rd_i,
  input  logic [31:0] b_wd_i,
  output logic        b_ready_o,
  input  logic        sb_set_i,
  input  logic [4:0]  sb_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        stall_o,
  output logic        hold_a_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wr_o,
  output logic [31:0] rf_wd_o
);

  localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_BUF
  } owner_e;

  logic        buf_valid;
  logic [4:0]  buf_rd;
  logic [31:0] buf_wd;
  logic [2:0]  age;
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  owner_e owner;
  logic   a_req;
  logic   forced;
  logic   drain;
  logic   b_xfer;

  assign a_req     = a_we_i && (a_rd_i != 5'd0);
  assign forced    = buf_valid && (age == AGE_LIM);
  assign b_ready_o = ~buf_valid && ~rst_i;
  assign b_xfer    = b_valid_i && b_ready_o;

  always_comb begin
    owner = OWN_NONE;
    if (forced) begin
      owner = OWN_BUF;
    end else if (a_req) begin
      owner = OWN_A;
    end else if (buf_valid) begin
      owner = OWN_BUF;
    end
  end

  // Outputs are forced quiet while reset is asserted, even with stale buffer state.
  assign drain = (owner == OWN_BUF) && ~rst_i;

  always_comb begin
    rf_we_o  = 1'b0;
    rf_wr_o  = 5'd0;
    rf_wd_o  = 32'd0;
    hold_a_o = 1'b0;
    if (!rst_i) begin
      unique case (owner)
        OWN_A: begin
          rf_we_o = 1'b1;
          rf_wr_o = a_rd_i;
          rf_wd_o = a_wd_i;
        end
        OWN_BUF: begin
          rf_we_o  = 1'b1;
          rf_wr_o  = buf_rd;
          rf_wd_o  = buf_wd;
          hold_a_o = forced && a_req;
        end
        default: ;
      endcase
    end
  end

  // Clear from a drain first so a same-cycle set of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (drain) begin
      busy_nxt[buf_rd] = 1'b0;
    end
    if (sb_set_i && (sb_rd_i != 5'd0)) begin
      busy_nxt[sb_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  assign stall_o = ~rst_i & (busy[rs1_i] | busy[rs2_i] | (sb_set_i & busy[sb_rd_i]));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
      buf_rd    <= 5'd0;
      buf_wd    <= 32'd0;
      age       <= 3'd0;
      busy      <= 32'd0;
    end else begin
      if (drain) begin
        buf_valid <= 1'b0;
        age       <= 3'd0;
      end else if (b_xfer && (b_rd_i != 5'd0)) begin
        buf_valid <= 1'b1;
        buf_rd    <= b_rd_i;
        buf_wd    <= b_wd_i;
        age       <= 3'd0;
      end else if (buf_valid && (age != AGE_LIM)) begin
        age <= age + 3'd1;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: expected register-file writes are queued as stimulus is
// driven and matched in order whenever the write port fires.
module tb_rf_wb_sched;
  localparam int unsigned AGE_MAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_we_i;
  logic [4:0]  a_rd_i;
  logic [31:0] a_wd_i;
  logic        b_valid_i;
  logic [4:0]  b_rd_i;
  logic [31:0] b_wd_i;
  logic        b_ready_o;
  logic        sb_set_i;
  logic [4:0]  sb_rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        stall_o;
  logic        hold_a_o;
  logic        rf_we_o;
  logic [4:0]  rf_wr_o;
  logic [31:0] rf_wd_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [36:0] sb_q[$];

  rf_wb_sched #(.AGE_MAX(AGE_MAX)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_we_i    (a_we_i),
    .a_rd_i    (a_rd_i),
    .a_wd_i    (a_wd_i),
    .b_valid_i (b_valid_i),
    .b_rd_i    (b_rd_i),
    .b_wd_i    (b_wd_i),
    .b_ready_o (b_ready_o),
    .sb_set_i  (sb_set_i),
    .sb_rd_i   (sb_rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .stall_o   (stall_o),
    .hold_a_o  (hold_a_o),
    .rf_we_o   (rf_we_o),
    .rf_wr_o   (rf_wr_o),
    .rf_wd_o   (rf_wd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
    sb_q.push_back({rd, wd});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    logic [36:0] e;
    if (rf_we_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", {31'd0, rf_we_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_rd", {27'd0, rf_wr_o}, {27'd0, e[36:32]});
        chk("wr_wd", rf_wd_o, e[31:0]);
      end
    end
  end

  initial begin
    rst_i = 1'b1; a_we_i = 1'b0; a_rd_i = '0; a_wd_i = '0;
    b_valid_i = 1'b0; b_rd_i = '0; b_wd_i = '0;
    sb_set_i = 1'b0; sb_rd_i = '0; rs1_i = '0; rs2_i = '0;

    // Reset
    tick(); tick(); settle();
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_wr", {27'd0, rf_wr_o}, 32'd0);
    chk("rst_wd", rf_wd_o, 32'd0);
    chk("rst_hold", {31'd0, hold_a_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_bready", {31'd0, b_ready_o}, 32'd0);
    tick(); rst_i = 1'b0; settle();
    chk("post_rst_bready", {31'd0, b_ready_o}, 32'd1);
    chk("post_rst_we", {31'd0, rf_we_o}, 32'd0);

    // Port A alone writes in the same cycle
    tick(); a_we_i = 1'b1; a_rd_i = 5'd5; a_wd_i = 32'h1234; expect_wr(5'd5, 32'h1234); settle();
    chk("a_only_we", {31'd0, rf_we_o}, 32'd1);
    chk("a_only_hold", {31'd0, hold_a_o}, 32'd0);

    // Port B on idle port, scoreboard on x7
    tick(); a_we_i = 1'b0; sb_set_i = 1'b1; sb_rd_i = 5'd7; rs1_i = 5'd7; settle();
    chk("b_stall_nobypass", {31'd0, stall_o}, 32'd0);
    tick(); sb_set_i = 1'b0; b_valid_i = 1'b1; b_rd_i = 5'd7; b_wd_i = 32'hCAFE; settle();
    chk("b_stall_busy", {31'd0, stall_o}, 32'd1);
    chk("b_bready_idle", {31'd0, b_ready_o}, 32'd1);
    tick(); b_valid_i = 1'b0; expect_wr(5'd7, 32'hCAFE); settle();
    chk("b_drain_we", {31'd0, rf_we_o}, 32'd1);
    chk("b_stall_until_edge", {31'd0, stall_o}, 32'd1);
    chk("b_bready_full", {31'd0, b_ready_o}, 32'd0);
    tick(); settle();
    chk("b_stall_cleared", {31'd0, stall_o}, 32'd0);
    chk("b_bready_again", {31'd0, b_ready_o}, 32'd1);

    // Starvation: port A hogs the port until the buffer reaches AGE_MAX
    tick(); rs1_i = 5'd0; b_valid_i = 1'b1; b_rd_i = 5'd10; b_wd_i = 32'hB0B0; settle();
    tick(); b_valid_i = 1'b0; a_we_i = 1'b1; a_rd_i = 5'd3;
    for (int i = 0; i < int'(AGE_MAX); i++) begin
      a_wd_i = 32'hA000 + 32'(i);
      expect_wr(5'd3, a_wd_i);
      settle();
      chk("starve_hold", {31'd0, hold_a_o}, 32'd0);
      chk("starve_bready", {31'd0, b_ready_o}, 32'd0);
      tick();
    end
    a_wd_i = 32'hA003; expect_wr(5'd10, 32'hB0B0); settle();
    chk("starve_forced_hold", {31'd0, hold_a_o}, 32'd1);
    tick(); expect_wr(5'd3, 32'hA003); settle();
    chk("starve_replay_hold", {31'd0, hold_a_o}, 32'd0);
    chk("starve_bready_after", {31'd0, b_ready_o}, 32'd1);
    tick(); a_we_i = 1'b0;

    // x0 handling on both ports
    b_valid_i = 1'b1; b_rd_i = 5'd12; b_wd_i = 32'h12; settle();
    tick(); b_valid_i = 1'b0; a_we_i = 1'b1; a_rd_i = 5'd0; a_wd_i = 32'hDEAD;
    expect_wr(5'd12, 32'h12); settle();
    chk("x0_a_hold", {31'd0, hold_a_o}, 32'd0);
    chk("x0_a_wr", {27'd0, rf_wr_o}, 32'd12);
    tick(); a_we_i = 1'b0; b_valid_i = 1'b1; b_rd_i = 5'd0; b_wd_i = 32'hFFFF; settle();
    chk("x0_b_bready", {31'd0, b_ready_o}, 32'd1);
    tick(); b_valid_i = 1'b0; settle();
    chk("x0_b_nofill", {31'd0, b_ready_o}, 32'd1);
    chk("x0_b_nowrite", {31'd0, rf_we_o}, 32'd0);

    // Same-cycle set and drain on x9: set wins
    tick(); sb_set_i = 1'b1; sb_rd_i = 5'd9; settle();
    tick(); sb_set_i = 1'b0; b_valid_i = 1'b1; b_rd_i = 5'd9; b_wd_i = 32'h99; settle();
    tick(); b_valid_i = 1'b0; sb_set_i = 1'b1; sb_rd_i = 5'd9; expect_wr(5'd9, 32'h99); settle();
    tick(); sb_set_i = 1'b0; rs2_i = 5'd9; settle();
    chk("setwins_stall", {31'd0, stall_o}, 32'd1);
    tick(); b_valid_i = 1'b1; b_rd_i = 5'd9; b_wd_i = 32'h999; settle();
    tick(); b_valid_i = 1'b0; expect_wr(5'd9, 32'h999); settle();
    tick(); settle();
    chk("busy9_cleared", {31'd0, stall_o}, 32'd0);
    tick(); rs2_i = 5'd0;

    // Reset with a full buffer and busy x4
    sb_set_i = 1'b1; sb_rd_i = 5'd4; settle();
    tick(); sb_set_i = 1'b0; b_valid_i = 1'b1; b_rd_i = 5'd20; b_wd_i = 32'h2020; rs1_i = 5'd4; settle();
    chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    tick(); b_valid_i = 1'b0; rst_i = 1'b1; settle();
    chk("midrst_we", {31'd0, rf_we_o}, 32'd0);
    chk("midrst_wr", {27'd0, rf_wr_o}, 32'd0);
    chk("midrst_wd", rf_wd_o, 32'd0);
    chk("midrst_hold", {31'd0, hold_a_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_bready", {31'd0, b_ready_o}, 32'd0);
    tick(); rst_i = 1'b0; settle();
    chk("postrst_busy4", {31'd0, stall_o}, 32'd0);
    chk("postrst_bready", {31'd0, b_ready_o}, 32'd1);
    chk("postrst_we", {31'd0, rf_we_o}, 32'd0);
    tick(); tick(); settle();
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
